// File: rtl/fsm_lec_rtc_pkg.sv
// Shared definitions for the RTC read sweeper: state encodings, register map, sweep length.
// Macro RTC_LEC_TIMER_EN adds the three timer registers (0x41..0x43) to the sweep.
package fsm_lec_rtc_pkg;

  // Bus-cycle phases; the engine walks DIR..ESP2 and the sweep adds IDLE/FIN around it.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DIR  = 3'd1,
    ESP1 = 3'd2,
    DAT  = 3'd3,
    ESP2 = 3'd4,
    FIN  = 3'd5
  } estado_t;

  typedef enum logic [1:0] {
    B_IDLE = 2'd0,
    B_LEC  = 2'd1,
    B_FIN  = 2'd2
  } barrido_t;

  localparam logic [7:0] DIR_SEG      = 8'h21;
  localparam logic [7:0] DIR_MIN      = 8'h22;
  localparam logic [7:0] DIR_HORA     = 8'h23;
  localparam logic [7:0] DIR_DIA      = 8'h24;
  localparam logic [7:0] DIR_MES      = 8'h25;
  localparam logic [7:0] DIR_ANIO     = 8'h26;
  localparam logic [7:0] DIR_SEG_TIM  = 8'h41;
  localparam logic [7:0] DIR_MIN_TIM  = 8'h42;
  localparam logic [7:0] DIR_HORA_TIM = 8'h43;

`ifdef RTC_LEC_TIMER_EN
  localparam int N_REGS = 9;
`else
  localparam int N_REGS = 6;
`endif

  function automatic logic [7:0] dir_reg(input logic [3:0] idx);
    case (idx)
      4'd0:    return DIR_SEG;
      4'd1:    return DIR_MIN;
      4'd2:    return DIR_HORA;
      4'd3:    return DIR_DIA;
      4'd4:    return DIR_MES;
      4'd5:    return DIR_ANIO;
      4'd6:    return DIR_SEG_TIM;
      4'd7:    return DIR_MIN_TIM;
      4'd8:    return DIR_HORA_TIM;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/fsm_lec_rtc_ciclo.sv
// rtc_ciclo_lec: one multiplexed-bus read (address strobe, gap, read strobe, gap).
// start is sampled in IDLE and on the last ESP2 cycle so consecutive reads run gap-free.
module rtc_ciclo_lec
  import fsm_lec_rtc_pkg::*;
#(
  parameter int T_PULSO  = 10,
  parameter int T_ESPERA = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] direccion,
  input  logic [7:0] dato_in,
  output logic       a_d,
  output logic       cs,
  output logic       rd,
  output logic       wr,
  output logic       bus_oe,
  output logic [7:0] dato_out,
  output logic [7:0] dato,
  output logic       done
);

  localparam logic [7:0] P_REC = 8'(T_PULSO - 1);
  localparam logic [7:0] E_REC = 8'(T_ESPERA - 1);

  estado_t    fase, fase_nx;
  logic [7:0] cnt, cnt_nx;
  logic       ult;

  assign ult = (cnt == 8'd0);

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use <= so every flop samples pre-edge values, independent of block order.
    if (reset) begin
      fase <= IDLE;
      cnt  <= P_REC;
      dato <= 8'h00;
    end else begin
      fase <= fase_nx;
      cnt  <= cnt_nx;
      if (fase == DAT && ult) dato <= dato_in;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first; a path that skips an assignment would infer a latch.
    fase_nx  = fase;
    cnt_nx   = cnt - 8'd1;
    done     = 1'b0;
    a_d      = 1'b1;
    cs       = 1'b1;
    rd       = 1'b1;
    wr       = 1'b1;
    bus_oe   = 1'b0;
    dato_out = 8'h00;
    case (fase)
      IDLE: begin
        cnt_nx = P_REC;
        if (start) fase_nx = DIR;
      end
      DIR: begin
        a_d      = 1'b0;
        cs       = 1'b0;
        wr       = 1'b0;
        bus_oe   = 1'b1;
        dato_out = direccion;
        if (ult) begin
          fase_nx = ESP1;
          cnt_nx  = E_REC;
        end
      end
      ESP1: begin
        if (ult) begin
          fase_nx = DAT;
          cnt_nx  = P_REC;
        end
      end
      DAT: begin
        cs = 1'b0;
        rd = 1'b0;
        if (ult) begin
          fase_nx = ESP2;
          cnt_nx  = E_REC;
        end
      end
      ESP2: begin
        if (ult) begin
          done    = 1'b1;
          cnt_nx  = P_REC;
          fase_nx = start ? DIR : IDLE;
        end
      end
      default: begin
        fase_nx = IDLE;
        cnt_nx  = P_REC;
      end
    endcase
  end

endmodule

// File: rtl/fsm_lec_rtc.sv
// RTC read sweeper: reads the clock registers into shadows and commits them all at once in FIN.
// Macro RTC_LEC_TIMER_EN extends the sweep to the timer registers; otherwise those outputs are 0.
module fsm_lec_rtc
  import fsm_lec_rtc_pkg::*;
#(
  parameter int T_PULSO  = 10,
  parameter int T_ESPERA = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       do_it_lec,
  output logic       a_d,
  output logic       cs,
  output logic       rd,
  output logic       wr,
  output logic       bus_oe,
  output logic [7:0] dato_out,
  input  logic [7:0] dato_in,
  output logic [7:0] seg,
  output logic [7:0] min,
  output logic [7:0] hora,
  output logic [7:0] dia,
  output logic [7:0] mes,
  output logic [7:0] anio,
  output logic [7:0] seg_tim,
  output logic [7:0] min_tim,
  output logic [7:0] hora_tim,
  output logic       ocupado,
  output logic       listo
);

  localparam logic [3:0] IDX_ULT = 4'(N_REGS - 1);

  barrido_t   estado, estado_nx;
  logic [3:0] idx;
  logic       start, done;
  logic [7:0] dato_cap;
  logic [7:0] shadow [N_REGS];
  logic [7:0] out_q  [N_REGS];

  rtc_ciclo_lec #(
    .T_PULSO  (T_PULSO),
    .T_ESPERA (T_ESPERA)
  ) u_ciclo (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .direccion (dir_reg(idx)),
    .dato_in   (dato_in),
    .a_d       (a_d),
    .cs        (cs),
    .rd        (rd),
    .wr        (wr),
    .bus_oe    (bus_oe),
    .dato_out  (dato_out),
    .dato      (dato_cap),
    .done      (done)
  );

  always_comb begin
    estado_nx = estado;
    start     = 1'b0;
    listo     = 1'b0;
    ocupado   = (estado != B_IDLE);
    case (estado)
      B_IDLE: begin
        if (do_it_lec) begin
          start     = 1'b1;
          estado_nx = B_LEC;
        end
      end
      B_LEC: begin
        if (done) begin
          if (idx == IDX_ULT) estado_nx = B_FIN;
          else                start     = 1'b1;
        end
      end
      B_FIN: begin
        listo     = 1'b1;
        estado_nx = B_IDLE;
      end
      default: estado_nx = B_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: shadows and outputs are reset as well, so an aborted sweep leaves nothing behind to commit.
    if (reset) begin
      estado <= B_IDLE;
      idx    <= 4'd0;
      for (int i = 0; i < N_REGS; i++) begin
        shadow[i] <= 8'h00;
        out_q[i]  <= 8'h00;
      end
    end else begin
      estado <= estado_nx;
      case (estado)
        B_IDLE: idx <= 4'd0;
        B_LEC: begin
          if (done) begin
            for (int i = 0; i < N_REGS; i++)
              if (idx == 4'(i)) shadow[i] <= dato_cap;
            idx <= idx + 4'd1;
          end
        end
        B_FIN: begin
          for (int i = 0; i < N_REGS; i++) out_q[i] <= shadow[i];
        end
        default: idx <= 4'd0;
      endcase
    end
  end

  assign seg  = out_q[0];
  assign min  = out_q[1];
  assign hora = out_q[2];
  assign dia  = out_q[3];
  assign mes  = out_q[4];
  assign anio = out_q[5];
`ifdef RTC_LEC_TIMER_EN
  assign seg_tim  = out_q[6];
  assign min_tim  = out_q[7];
  assign hora_tim = out_q[8];
`else
  assign seg_tim  = 8'h00;
  assign min_tim  = 8'h00;
  assign hora_tim = 8'h00;
`endif

endmodule

// File: tb/tb_fsm_lec_rtc.sv
// Bench for fsm_lec_rtc: an RTC register-file bus model answers reads; each sweep is checked
// cycle by cycle against timing derived from T_PULSO/T_ESPERA and against the model's register map.
module tb_fsm_lec_rtc;

  localparam int TP = 10;
  localparam int TE = 3;
  localparam int L  = 2 * TP + 2 * TE;
`ifdef RTC_LEC_TIMER_EN
  localparam int N = 9;
`else
  localparam int N = 6;
`endif
  localparam int T_SWEEP = N * L + 1;
  localparam logic [12:0] BUS_IDLE = {5'b11110, 8'h00};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       do_it_lec = 1'b0;
  logic [7:0] dato_in = 8'h00;
  logic       a_d, cs, rd, wr, bus_oe, ocupado, listo;
  logic [7:0] dato_out, seg, min, hora, dia, mes, anio, seg_tim, min_tim, hora_tim;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] rtc_mem  [256];
  logic [7:0] addr_tab [9];
  logic [7:0] exp_out  [9];

  always #5 clk = ~clk;

  fsm_lec_rtc #(.T_PULSO(TP), .T_ESPERA(TE)) dut (
    .clk(clk), .reset(reset), .do_it_lec(do_it_lec),
    .a_d(a_d), .cs(cs), .rd(rd), .wr(wr), .bus_oe(bus_oe),
    .dato_out(dato_out), .dato_in(dato_in),
    .seg(seg), .min(min), .hora(hora), .dia(dia), .mes(mes), .anio(anio),
    .seg_tim(seg_tim), .min_tim(min_tim), .hora_tim(hora_tim),
    .ocupado(ocupado), .listo(listo)
  );

  // RTC model: latches the address strobe, returns the register only on the last read-strobe cycle.
  logic [7:0] lat = 8'h00;
  int rd_run = 0;
  always @(negedge clk) begin
    if (!a_d && !cs && bus_oe) lat = dato_out;
    if (!rd && !cs) rd_run = rd_run + 1;
    else            rd_run = 0;
    dato_in = (rd_run == TP) ? rtc_mem[lat] : 8'($urandom);
  end

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [12:0] bus_obs();
    return {a_d, cs, rd, wr, bus_oe, (bus_oe ? dato_out : 8'h00)};
  endfunction

  // Expected strobes for cycle c (1 = first address-phase cycle) of a sweep.
  function automatic logic [12:0] bus_exp(input int c);
    int r, o;
    r = (c - 1) / L;
    o = (c - 1) % L;
    if (o < TP)                return {5'b00101, addr_tab[r]};
    else if (o < TP + TE)      return BUS_IDLE;
    else if (o < 2 * TP + TE)  return {5'b10010, 8'h00};
    else                       return BUS_IDLE;
  endfunction

  function automatic logic [71:0] out_obs();
    return {seg, min, hora, dia, mes, anio, seg_tim, min_tim, hora_tim};
  endfunction

  function automatic logic [71:0] out_exp();
    return {exp_out[0], exp_out[1], exp_out[2], exp_out[3], exp_out[4],
            exp_out[5], exp_out[6], exp_out[7], exp_out[8]};
  endfunction

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("idle_ocupado", 80'(ocupado), 80'(0));
      check("idle_listo", 80'(listo), 80'(0));
      check("idle_bus", 80'(bus_obs()), 80'(BUS_IDLE));
      check("idle_outputs", 80'(out_obs()), 80'(out_exp()));
    end
  endtask

  // Caller has just raised do_it_lec; the next falling edge is the first DIR cycle.
  task automatic sweep(input bit hold, input int chg_at, input int rst_at);
    for (int c = 1; c <= T_SWEEP; c++) begin
      @(negedge clk);
      if (c == 1 && !hold) do_it_lec = 1'b0;
      if (c == chg_at) rtc_mem[8'h21] = rtc_mem[8'h21] ^ 8'h5A;
      if (c == rst_at) begin
        reset = 1'b1;
        #1;
        for (int i = 0; i < 9; i++) exp_out[i] = 8'h00;
        check("rst_bus", 80'(bus_obs()), 80'(BUS_IDLE));
        check("rst_ocupado", 80'(ocupado), 80'(0));
        check("rst_listo", 80'(listo), 80'(0));
        check("rst_outputs", 80'(out_obs()), 80'(out_exp()));
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      if (c < T_SWEEP) begin
        check("bus_timing", 80'(bus_obs()), 80'(bus_exp(c)));
        check("ocupado", 80'(ocupado), 80'(1));
        check("listo_early", 80'(listo), 80'(0));
        check("coherent", 80'(out_obs()), 80'(out_exp()));
      end else begin
        check("listo_at_end", 80'(listo), 80'(1));
        check("fin_ocupado", 80'(ocupado), 80'(1));
        check("fin_bus", 80'(bus_obs()), 80'(BUS_IDLE));
      end
    end
    for (int i = 0; i < 9; i++) exp_out[i] = (i < N) ? rtc_mem[addr_tab[i]] : 8'h00;
    @(negedge clk);
    check("commit", 80'(out_obs()), 80'(out_exp()));
    check("after_fin_ocupado", 80'(ocupado), 80'(0));
    check("after_fin_listo", 80'(listo), 80'(0));
    check("after_fin_bus", 80'(bus_obs()), 80'(BUS_IDLE));
  endtask

  initial begin
    logic [71:0] spec_vals;
    addr_tab = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
    for (int i = 0; i < 256; i++) rtc_mem[i] = 8'($urandom);
    for (int i = 0; i < 9; i++) exp_out[i] = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_bus", 80'(bus_obs()), 80'(BUS_IDLE));
    check("reset_ocupado", 80'(ocupado), 80'(0));
    check("reset_listo", 80'(listo), 80'(0));
    check("reset_outputs", 80'(out_obs()), 80'(out_exp()));
    reset = 1'b0;
    idle(3);

    // Known register contents, one-cycle request
    rtc_mem[8'h21] = 8'h45; rtc_mem[8'h22] = 8'h30; rtc_mem[8'h23] = 8'h12;
    rtc_mem[8'h24] = 8'h07; rtc_mem[8'h25] = 8'h10; rtc_mem[8'h26] = 8'h16;
    rtc_mem[8'h41] = 8'h05; rtc_mem[8'h42] = 8'h02; rtc_mem[8'h43] = 8'h01;
    do_it_lec = 1'b1;
    sweep(1'b0, 0, 0);
`ifdef RTC_LEC_TIMER_EN
    spec_vals = 72'h45_30_12_07_10_16_05_02_01;
`else
    spec_vals = 72'h45_30_12_07_10_16_00_00_00;
`endif
    check("spec_snapshot", 80'(out_obs()), 80'(spec_vals));
    idle(4);

    // Random contents, request held high: back-to-back sweeps, seg changed mid-sweep in the second
    for (int i = 0; i < 9; i++) rtc_mem[addr_tab[i]] = 8'($urandom);
    do_it_lec = 1'b1;
    sweep(1'b1, 0, 0);
    sweep(1'b1, 5, 0);
    sweep(1'b0, 0, 0);
    idle(3);

    // Reset at cycle 100 of a sweep, then a clean sweep from idx 0
    for (int i = 0; i < 9; i++) rtc_mem[addr_tab[i]] = 8'($urandom);
    do_it_lec = 1'b1;
    sweep(1'b0, 0, 100);
    idle(300);
    do_it_lec = 1'b1;
    sweep(1'b0, 0, 0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
